// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream program loader into instruction RAM, holds CPU in reset until checksum passes
module imem_boot_loader #(
  parameter int ADDR_W = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [16:0] MAX_LEN = 17'(DEPTH);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, words_q, words_d, len_full;
  logic [1:0] idx_q, idx_d;
  logic [7:0] csum_q, csum_d, csum_sum;
  logic [23:0] word_q, word_d;
  logic rx_ready_q, rx_ready_d, cpu_reset_q, cpu_reset_d, load_done_q, load_done_d, load_error_q, load_error_d;
  logic acc, we;
  logic [31:0] ram [DEPTH];
  logic unused_pc;
  assign acc = rx_valid && rx_ready_q;
  assign len_full = {rx_data, len_q[7:0]};
  assign csum_sum = csum_q + rx_data;
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};
  assign instruction = ram[pc[ADDR_W+1:2]];
  assign rx_ready = rx_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign load_error = load_error_q;
  assign words_loaded = words_q;
  // next-state, frame counters and registered output decode
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    words_d = words_q;
    idx_d = idx_q;
    csum_d = csum_q;
    word_d = word_q;
    we = 1'b0;
    unique case (state_q)
      IDLE: state_d = (acc && rx_data == SYNC_BYTE) ? LEN_LO : IDLE;
      LEN_LO: if (acc) begin
        len_d[7:0] = rx_data;
        state_d = LEN_HI;
      end
      LEN_HI: if (acc) begin
        len_d[15:8] = rx_data;
        words_d = '0;
        idx_d = '0;
        csum_d = '0;
        state_d = (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) ? ERROR : DATA;
      end
      DATA: if (acc) begin
        csum_d = csum_sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          we = 1'b1;
          words_d = words_q + 16'd1;
          state_d = (words_d == len_q) ? CSUM : DATA;
        end else
          word_d[{idx_q, 3'b0} +: 8] = rx_data;
      end
      CSUM: if (acc) state_d = (csum_sum == 8'd0) ? RUN : ERROR;
      default: ;
    endcase
    rx_ready_d = !(state_d == RUN || state_d == ERROR);
    cpu_reset_d = state_d != RUN;
    load_done_d = state_d == RUN;
    load_error_d = state_d == ERROR;
  end
  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      words_q <= '0;
      idx_q <= '0;
      csum_q <= '0;
      word_q <= '0;
      rx_ready_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      words_q <= words_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      word_q <= word_d;
      rx_ready_q <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_error_q <= load_error_d;
    end
  end
  // word write on the 4th byte; contents survive reset
  always_ff @(posedge clk) begin
    if (we && !reset) ram[words_q[ADDR_W-1:0]] <= {rx_data, word_q};
  end
endmodule
